// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing X^E mod M on a shared
// Montgomery multiplier core, including entry to and exit from the Montgomery domain.
module mont_exp_ctrl #(
    parameter int DATA_W = 1024,
    parameter int E_BITS = 1024,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_x,
    input  logic [E_BITS-1:0] in_e,
    input  logic [DATA_W-1:0] in_m,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_r2,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              busy,
    output logic              mul_start,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    output logic [DATA_W-1:0] mul_m,
    input  logic [DATA_W-1:0] mul_result,
    input  logic              mul_done
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        TM_ISSUE = 4'd1,
        TM_WAIT  = 4'd2,
        SQ_ISSUE = 4'd3,
        SQ_WAIT  = 4'd4,
        ML_ISSUE = 4'd5,
        ML_WAIT  = 4'd6,
        NEXT     = 4'd7,
        FM_ISSUE = 4'd8,
        FM_WAIT  = 4'd9,
        DONE     = 4'd10
    } state_t;

    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [E_BITS-1:0] E_ZERO    = {E_BITS{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(E_BITS - 1);

    state_t            state_r;
    state_t            next_state_s;
    logic [DATA_W-1:0] xr_r;
    logic [E_BITS-1:0] er_r;
    logic [DATA_W-1:0] mr_r;
    logic [DATA_W-1:0] r2r_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] xt_r;
    logic [CNT_W-1:0]  i_r;
    logic [DATA_W-1:0] result_r;
    logic              done_r;
    logic              busy_r;
    logic              mul_start_r;
    logic [DATA_W-1:0] mul_a_r;
    logic [DATA_W-1:0] mul_b_r;
    logic [DATA_W-1:0] op_a_s;
    logic [DATA_W-1:0] op_b_s;
    logic              issue_s;

    // Next-state logic of the square-and-multiply sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = TM_ISSUE;
                else       next_state_s = IDLE;
            end
            TM_ISSUE: next_state_s = TM_WAIT;
            TM_WAIT: begin
                if (mul_done) next_state_s = SQ_ISSUE;
                else          next_state_s = TM_WAIT;
            end
            SQ_ISSUE: next_state_s = SQ_WAIT;
            SQ_WAIT: begin
                if (mul_done) begin
                    if (er_r[E_BITS-1]) next_state_s = ML_ISSUE;
                    else                next_state_s = NEXT;
                end else begin
                    next_state_s = SQ_WAIT;
                end
            end
            ML_ISSUE: next_state_s = ML_WAIT;
            ML_WAIT: begin
                if (mul_done) next_state_s = NEXT;
                else          next_state_s = ML_WAIT;
            end
            NEXT: begin
                if (i_r == CNT_ZERO) next_state_s = FM_ISSUE;
                else                 next_state_s = SQ_ISSUE;
            end
            FM_ISSUE: next_state_s = FM_WAIT;
            FM_WAIT: begin
                if (mul_done) next_state_s = DONE;
                else          next_state_s = FM_WAIT;
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Operands are chosen one cycle ahead so they are already stable in the
    // launch cycle; the multiply step bypasses the square result arriving now.
    always_comb begin
        op_a_s  = mul_a_r;
        op_b_s  = mul_b_r;
        issue_s = 1'b0;
        case (next_state_s)
            TM_ISSUE: begin
                op_a_s  = in_x;
                op_b_s  = in_r2;
                issue_s = 1'b1;
            end
            SQ_ISSUE: begin
                op_a_s  = a_r;
                op_b_s  = a_r;
                issue_s = 1'b1;
            end
            ML_ISSUE: begin
                op_a_s  = mul_result;
                op_b_s  = xt_r;
                issue_s = 1'b1;
            end
            FM_ISSUE: begin
                op_a_s  = a_r;
                op_b_s  = DATA_ONE;
                issue_s = 1'b1;
            end
            default: begin
                op_a_s  = mul_a_r;
                op_b_s  = mul_b_r;
                issue_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= next_state_s;
    end

    // Operand latching and accumulator/counter updates per state.
    always_ff @(posedge clk) begin
        if (reset) begin
            xr_r     <= DATA_ZERO;
            er_r     <= E_ZERO;
            mr_r     <= DATA_ZERO;
            r2r_r    <= DATA_ZERO;
            a_r      <= DATA_ZERO;
            xt_r     <= DATA_ZERO;
            i_r      <= CNT_ZERO;
            result_r <= DATA_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        xr_r  <= in_x;
                        er_r  <= in_e;
                        mr_r  <= in_m;
                        r2r_r <= in_r2;
                        a_r   <= in_r;
                        i_r   <= CNT_LAST;
                    end
                end
                TM_WAIT: begin
                    if (mul_done) xt_r <= mul_result;
                end
                SQ_WAIT, ML_WAIT: begin
                    if (mul_done) a_r <= mul_result;
                end
                NEXT: begin
                    if (i_r != CNT_ZERO) begin
                        i_r  <= i_r - CNT_ONE;
                        er_r <= {er_r[E_BITS-2:0], 1'b0};
                    end
                end
                FM_WAIT: begin
                    if (mul_done) result_r <= mul_result;
                end
                default: begin
                end
            endcase
        end
    end

    // Registered handshake outputs and multiplier operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            mul_start_r <= 1'b0;
            mul_a_r     <= DATA_ZERO;
            mul_b_r     <= DATA_ZERO;
        end else begin
            done_r      <= (next_state_s == DONE);
            busy_r      <= (next_state_s != IDLE);
            mul_start_r <= issue_s;
            mul_a_r     <= op_a_s;
            mul_b_r     <= op_b_s;
        end
    end

    assign result    = result_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign mul_start = mul_start_r;
    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;
    assign mul_m     = mr_r;

endmodule
